// File: rtl/rob_param_nw_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : rob_pkg
//  Brief   : Shared types, constants and helpers for the reorder buffer.
//  Rev     : 1.0  initial release
// ============================================================================
package rob_pkg;

   // Default-configuration geometry (32-entry ROB)
   localparam int DEF_DEPTH  = 32;
   localparam int TAG_W      = $clog2(DEF_DEPTH);
   localparam int PTR_W      = TAG_W + 1;
   localparam int DEF_ARCH_W = 5;
   localparam int DEF_PHY_W  = 6;
   localparam int DEF_ADDR_W = 32;

   // Entry layout at default widths; the top builds the same layout from its parameters
   typedef struct packed {
      logic                  cmpl;
      logic                  regw;
      logic [DEF_ARCH_W-1:0] rd;
      logic [DEF_PHY_W-1:0]  cur;
      logic [DEF_PHY_W-1:0]  prev;
      logic                  sw;
      logic [DEF_ADDR_W-1:0] addr;
   } rob_entry_t;

   // True when tag lies in the live window [rd, wr); pointers carry the wrap bit
   function automatic logic in_window(input int unsigned tag, input int unsigned rd,
                                      input int unsigned wr, input int unsigned depth);
      int unsigned w_off;
      int unsigned w_occ;
      w_off = (tag - rd) & (depth - 1);
      w_occ = (wr - rd) & (2 * depth - 1);
      return w_off < w_occ;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rob_param_nw_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : rob_ptr_ctrl
//  Brief   : Head/tail pointers, full/empty, flush rollback and replicated
//            head-pointer registers for the reorder buffer.
//  Rev     : 1.0  initial release
// ============================================================================
module rob_ptr_ctrl
   import rob_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int NUM_TOPCP = 10,
   parameter int IDX_W     = $clog2(DEPTH),
   parameter int PTR_BITS  = IDX_W + 1
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_dispatch,
   input  logic                          i_commit,
   input  logic                          i_flush,
   input  logic [IDX_W-1:0]              i_flush_tag,
   output logic [PTR_BITS-1:0]           o_rd_ptr,
   output logic [PTR_BITS-1:0]           o_wr_ptr,
   output logic                          o_empty,
   output logic                          o_full,
   output logic [NUM_TOPCP*PTR_BITS-1:0] o_top_ptr
);

   logic [PTR_BITS-1:0] r_rd;
   logic [PTR_BITS-1:0] r_wr;
   logic [PTR_BITS-1:0] w_rd_nxt;
   logic [PTR_BITS-1:0] w_wr_nxt;
   logic                w_full_raw;

   assign o_rd_ptr   = r_rd;
   assign o_wr_ptr   = r_wr;
   assign o_empty    = (r_rd == r_wr);
   assign w_full_raw = ((r_rd ^ r_wr) == {1'b1, {IDX_W{1'b0}}});
   // A retiring head frees a slot in the same cycle, so full drops with commit
   assign o_full     = w_full_raw && !i_commit;

   // Next-pointer logic: flush rollback has priority over dispatch
   always_comb begin
      w_rd_nxt = i_commit ? r_rd + 1'b1 : r_rd;
      w_wr_nxt = r_wr;
      if (i_flush) begin
         // Rolling back to an index at or below the tail stays in the same lap
         w_wr_nxt = {(i_flush_tag <= r_wr[IDX_W-1:0]) ? r_wr[IDX_W] : ~r_wr[IDX_W],
                     i_flush_tag};
      end else if (i_dispatch) begin
         w_wr_nxt = r_wr + 1'b1;
      end
   end

   // Pointer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd <= '0;
         r_wr <= '0;
      end else begin
         r_rd <= w_rd_nxt;
         r_wr <= w_wr_nxt;
      end
   end

   // Independent head-pointer copies, one register set per fan-out consumer
   for (genvar g = 0; g < NUM_TOPCP; g++) begin : g_topcp
      logic [PTR_BITS-1:0] r_top;
      // Copy tracks the head pointer
      always_ff @(posedge clk or posedge rst) begin
         if (rst)           r_top <= '0;
         else if (i_commit) r_top <= r_rd + 1'b1;
      end
      assign o_top_ptr[g*PTR_BITS +: PTR_BITS] = r_top;
   end

endmodule
`default_nettype wire

// File: rtl/rob_param_nw.sv
`default_nettype none
// ============================================================================
//  Module  : rob_param_nw
//  Brief   : Parametrised reorder buffer: in-order allocate, out-of-order
//            completion from NUM_CDB buses, in-order commit, flush rollback.
//  Config  : define ROB_OCCUPANCY_EN to add Rob_Count / Rob_AlmostFull.
//  Rev     : 1.0  initial release
// ============================================================================
module rob_param_nw
   import rob_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int ARCH_W    = DEF_ARCH_W,
   parameter int PHY_W     = DEF_PHY_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int NUM_CDB   = 1,
   parameter int NUM_TOPCP = 10,
   parameter int IDX_W     = $clog2(DEPTH),
   parameter int PTR_BITS  = IDX_W + 1
)(
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          Dis_InstValid,
   input  logic                          Dis_InstSw,
   input  logic                          Dis_RegWrite,
   input  logic [ARCH_W-1:0]             Dis_RobRdAddr,
   input  logic [PHY_W-1:0]              Dis_NewRdPhyAddr,
   input  logic [PHY_W-1:0]              Dis_PrevPhyAddr,
   input  logic [PHY_W-1:0]              Dis_SwRtPhyAddr,
   output logic                          Rob_Full,
   output logic [IDX_W-1:0]              Rob_BottomPtr,
   input  logic [NUM_CDB-1:0]            Cdb_Valid,
   input  logic [NUM_CDB*IDX_W-1:0]      Cdb_RobTag,
   input  logic [NUM_CDB*ADDR_W-1:0]     Cdb_SwAddr,
   input  logic                          Cdb_Flush,
   input  logic [IDX_W-1:0]              Cfc_RobTag,
   input  logic                          SB_Full,
   output logic                          Rob_Commit,
   output logic                          Rob_CommitMemWrite,
   output logic [ADDR_W-1:0]             Rob_SwAddr,
   output logic                          Rob_CommitRegWrite,
   output logic [ARCH_W-1:0]             Rob_CommitRdAddr,
   output logic [PHY_W-1:0]              Rob_CommitCurrPhyAddr,
   output logic [PHY_W-1:0]              Rob_CommitPrePhyAddr,
`ifdef ROB_OCCUPANCY_EN
   output logic [PTR_BITS-1:0]           Rob_Count,
   output logic                          Rob_AlmostFull,
`endif
   output logic [NUM_TOPCP*PTR_BITS-1:0] Rob_TopPtr
);

   // Payload fields; completion bits are kept apart so only they carry reset
   typedef struct packed {
      logic              regw;
      logic [ARCH_W-1:0] rd;
      logic [PHY_W-1:0]  cur;
      logic [PHY_W-1:0]  prev;
      logic              sw;
      logic [ADDR_W-1:0] addr;
   } entry_t;

   entry_t              r_ent [DEPTH];
   logic [DEPTH-1:0]    r_cmpl;

   logic [PTR_BITS-1:0] w_rd;
   logic [PTR_BITS-1:0] w_wr;
   logic [IDX_W-1:0]    w_rd_idx;
   logic [IDX_W-1:0]    w_wr_idx;
   logic                w_empty;
   logic                w_dis_acc;
   entry_t              w_head;
   logic [NUM_CDB-1:0]  w_cdb_ok;
   logic [IDX_W-1:0]    w_cdb_tag  [NUM_CDB];
   logic [ADDR_W-1:0]   w_cdb_addr [NUM_CDB];

   rob_ptr_ctrl #(
      .DEPTH     (DEPTH),
      .NUM_TOPCP (NUM_TOPCP),
      .IDX_W     (IDX_W),
      .PTR_BITS  (PTR_BITS)
   ) u_ptr (
      .clk         (Clk),
      .rst         (Reset),
      .i_dispatch  (w_dis_acc),
      .i_commit    (Rob_Commit),
      .i_flush     (Cdb_Flush),
      .i_flush_tag (Cfc_RobTag),
      .o_rd_ptr    (w_rd),
      .o_wr_ptr    (w_wr),
      .o_empty     (w_empty),
      .o_full      (Rob_Full),
      .o_top_ptr   (Rob_TopPtr)
   );

   assign w_rd_idx      = w_rd[IDX_W-1:0];
   assign w_wr_idx      = w_wr[IDX_W-1:0];
   assign Rob_BottomPtr = w_wr_idx;
   assign w_dis_acc     = Dis_InstValid && !Cdb_Flush && !Rob_Full;

   // Per-bus unpacking; tags outside the live window are ignored
   for (genvar b = 0; b < NUM_CDB; b++) begin : g_cdb
      assign w_cdb_tag[b]  = Cdb_RobTag[b*IDX_W +: IDX_W];
      assign w_cdb_addr[b] = Cdb_SwAddr[b*ADDR_W +: ADDR_W];
      assign w_cdb_ok[b]   = Cdb_Valid[b] && !Cdb_Flush &&
                             in_window(32'(w_cdb_tag[b]), 32'(w_rd), 32'(w_wr), DEPTH);
   end

   // Completion bits: set by CDB, cleared when the slot is reallocated
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_cmpl <= '0;
      end else begin
         for (int b = 0; b < NUM_CDB; b++) begin
            if (w_cdb_ok[b]) r_cmpl[w_cdb_tag[b]] <= 1'b1;
         end
         if (w_dis_acc) r_cmpl[w_wr_idx] <= 1'b0;
      end
   end

   // Payload write: dispatch fields and store addresses (lowest bus written last wins)
   always_ff @(posedge Clk) begin
      for (int b = NUM_CDB - 1; b >= 0; b--) begin
         if (w_cdb_ok[b] && r_ent[w_cdb_tag[b]].sw) r_ent[w_cdb_tag[b]].addr <= w_cdb_addr[b];
      end
      if (w_dis_acc) begin
         r_ent[w_wr_idx].regw <= Dis_RegWrite && !Dis_InstSw;
         r_ent[w_wr_idx].rd   <= Dis_RobRdAddr;
         r_ent[w_wr_idx].cur  <= Dis_InstSw ? Dis_SwRtPhyAddr : Dis_NewRdPhyAddr;
         r_ent[w_wr_idx].prev <= Dis_PrevPhyAddr;
         r_ent[w_wr_idx].sw   <= Dis_InstSw;
      end
   end

   // Commit decision and head-entry output muxing
   always_comb begin
      w_head                = r_ent[w_rd_idx];
      Rob_Commit            = !w_empty && r_cmpl[w_rd_idx] && !(w_head.sw && SB_Full);
      Rob_CommitMemWrite    = Rob_Commit && w_head.sw;
      Rob_SwAddr            = w_head.addr;
      Rob_CommitRegWrite    = w_head.regw;
      Rob_CommitRdAddr      = w_head.rd;
      Rob_CommitCurrPhyAddr = w_head.cur;
      Rob_CommitPrePhyAddr  = w_head.prev;
   end

`ifdef ROB_OCCUPANCY_EN
   // Occupancy from pointer distance; wrap bit makes DEPTH representable
   always_comb begin
      Rob_Count      = w_wr - w_rd;
      Rob_AlmostFull = (Rob_Count >= PTR_BITS'(DEPTH - 2));
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rob_param_nw.sv
`default_nettype none
// ============================================================================
//  Module  : tb_rob_param_nw
//  Brief   : Scoreboard bench for rob_param_nw (DEPTH=32, NUM_CDB=2).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_rob_param_nw;

   logic        Clk, Reset;
   logic        Dis_InstValid, Dis_InstSw, Dis_RegWrite;
   logic [4:0]  Dis_RobRdAddr;
   logic [5:0]  Dis_NewRdPhyAddr, Dis_PrevPhyAddr, Dis_SwRtPhyAddr;
   logic        Rob_Full;
   logic [4:0]  Rob_BottomPtr;
   logic [1:0]  Cdb_Valid;
   logic [9:0]  Cdb_RobTag;
   logic [63:0] Cdb_SwAddr;
   logic        Cdb_Flush;
   logic [4:0]  Cfc_RobTag;
   logic        SB_Full;
   logic        Rob_Commit, Rob_CommitMemWrite, Rob_CommitRegWrite;
   logic [31:0] Rob_SwAddr;
   logic [4:0]  Rob_CommitRdAddr;
   logic [5:0]  Rob_CommitCurrPhyAddr, Rob_CommitPrePhyAddr;
   logic [59:0] Rob_TopPtr;
`ifdef ROB_OCCUPANCY_EN
   logic [5:0]  Rob_Count;
   logic        Rob_AlmostFull;
`endif

   rob_param_nw #(.DEPTH(32), .NUM_CDB(2), .NUM_TOPCP(10)) dut (
      .Clk(Clk), .Reset(Reset),
      .Dis_InstValid(Dis_InstValid), .Dis_InstSw(Dis_InstSw), .Dis_RegWrite(Dis_RegWrite),
      .Dis_RobRdAddr(Dis_RobRdAddr), .Dis_NewRdPhyAddr(Dis_NewRdPhyAddr),
      .Dis_PrevPhyAddr(Dis_PrevPhyAddr), .Dis_SwRtPhyAddr(Dis_SwRtPhyAddr),
      .Rob_Full(Rob_Full), .Rob_BottomPtr(Rob_BottomPtr),
      .Cdb_Valid(Cdb_Valid), .Cdb_RobTag(Cdb_RobTag), .Cdb_SwAddr(Cdb_SwAddr),
      .Cdb_Flush(Cdb_Flush), .Cfc_RobTag(Cfc_RobTag), .SB_Full(SB_Full),
      .Rob_Commit(Rob_Commit), .Rob_CommitMemWrite(Rob_CommitMemWrite),
      .Rob_SwAddr(Rob_SwAddr), .Rob_CommitRegWrite(Rob_CommitRegWrite),
      .Rob_CommitRdAddr(Rob_CommitRdAddr), .Rob_CommitCurrPhyAddr(Rob_CommitCurrPhyAddr),
      .Rob_CommitPrePhyAddr(Rob_CommitPrePhyAddr),
`ifdef ROB_OCCUPANCY_EN
      .Rob_Count(Rob_Count), .Rob_AlmostFull(Rob_AlmostFull),
`endif
      .Rob_TopPtr(Rob_TopPtr)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   typedef struct {
      logic [4:0] tag;
      logic       regw;
      logic [4:0] rd;
      logic [5:0] cur;
      logic [5:0] prev;
      logic       sw;
   } exp_t;

   exp_t        q[$];
   logic [31:0] m_addr [32];
   logic [5:0]  m_rd, m_wr;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: every retirement is compared against the oldest expected entry
   always @(negedge Clk) begin
      exp_t e;
      if (!Reset && Rob_Commit) begin
         if (q.size() == 0) begin
            chk("commit_unexpected", {63'd0, Rob_Commit}, 64'd0);
         end else begin
            e = q.pop_front();
            chk("commit_tag", {59'd0, Rob_TopPtr[4:0]}, {59'd0, e.tag});
            for (int k = 0; k < 10; k++)
               chk("topptr_copy", {58'd0, Rob_TopPtr[k*6 +: 6]}, {58'd0, m_rd});
            chk("commit_regw", {63'd0, Rob_CommitRegWrite}, {63'd0, e.regw});
            chk("commit_rd",   {59'd0, Rob_CommitRdAddr}, {59'd0, e.rd});
            chk("commit_cur",  {58'd0, Rob_CommitCurrPhyAddr}, {58'd0, e.cur});
            chk("commit_prev", {58'd0, Rob_CommitPrePhyAddr}, {58'd0, e.prev});
            chk("commit_memw", {63'd0, Rob_CommitMemWrite}, {63'd0, e.sw});
            if (e.sw) chk("commit_swaddr", {32'd0, Rob_SwAddr}, {32'd0, m_addr[e.tag]});
            m_rd = m_rd + 6'd1;
         end
      end
   end

   task automatic tick();
      @(posedge Clk); #1;
   endtask

   task automatic neg();
      @(negedge Clk);
   endtask

   task automatic set_dis(input logic sw, input logic regw, input logic [4:0] rd,
                          input logic [5:0] np, input logic [5:0] pp, input logic [5:0] sp);
      exp_t e;
      Dis_InstValid = 1'b1; Dis_InstSw = sw; Dis_RegWrite = regw;
      Dis_RobRdAddr = rd; Dis_NewRdPhyAddr = np; Dis_PrevPhyAddr = pp; Dis_SwRtPhyAddr = sp;
      e.tag = m_wr[4:0]; e.regw = regw & ~sw; e.rd = rd;
      e.cur = sw ? sp : np; e.prev = pp; e.sw = sw;
      q.push_back(e);
      m_wr = m_wr + 6'd1;
   endtask

   task automatic dispatch_one(input logic sw, input logic regw, input logic [4:0] rd,
                               input logic [5:0] np, input logic [5:0] pp, input logic [5:0] sp);
      set_dis(sw, regw, rd, np, pp, sp);
      tick();
      Dis_InstValid = 1'b0;
   endtask

   task automatic dispatch_n(input int n, input int base);
      for (int i = 0; i < n; i++)
         dispatch_one(1'b0, 1'b1, 5'(base + i), 6'(base + i + 10), 6'(base + i + 20), 6'(base + i + 30));
   endtask

   function automatic logic live_sw(input logic [4:0] t);
      logic r;
      r = 1'b0;
      foreach (q[i]) if (q[i].tag == t && q[i].sw) r = 1'b1;
      return r;
   endfunction

   task automatic cdb(input logic v0, input logic [4:0] t0, input logic [31:0] a0,
                      input logic v1, input logic [4:0] t1, input logic [31:0] a1);
      Cdb_Valid = {v1, v0}; Cdb_RobTag = {t1, t0}; Cdb_SwAddr = {a1, a0};
      if (v1 && live_sw(t1)) m_addr[t1] = a1;
      if (v0 && live_sw(t0)) m_addr[t0] = a0;
      tick();
      Cdb_Valid = 2'b00;
   endtask

   task automatic flush(input logic [4:0] tag, input logic with_dis, input logic with_cdb,
                        input logic [4:0] cdb_tag);
      logic [5:0] nw;
      int keep;
      Cdb_Flush = 1'b1; Cfc_RobTag = tag;
      Dis_InstValid = with_dis; Cdb_Valid = {1'b0, with_cdb}; Cdb_RobTag = {5'd0, cdb_tag};
      nw = {(tag <= m_wr[4:0]) ? m_wr[5] : ~m_wr[5], tag};
      keep = int'(6'(nw - m_rd));
      while (q.size() > keep) void'(q.pop_back());
      m_wr = nw;
      tick();
      Cdb_Flush = 1'b0; Dis_InstValid = 1'b0; Cdb_Valid = 2'b00;
   endtask

   task automatic wait_rd(input logic [5:0] target, input int budget);
      for (int i = 0; i < budget && m_rd != target; i++) tick();
      chk("drain", {58'd0, m_rd}, {58'd0, target});
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1; Dis_InstValid = 0; Dis_InstSw = 0; Dis_RegWrite = 0;
      Dis_RobRdAddr = 0; Dis_NewRdPhyAddr = 0; Dis_PrevPhyAddr = 0; Dis_SwRtPhyAddr = 0;
      Cdb_Valid = 0; Cdb_RobTag = 0; Cdb_SwAddr = 0; Cdb_Flush = 0; Cfc_RobTag = 0; SB_Full = 0;
      m_rd = 0; m_wr = 0;
      for (int i = 0; i < 32; i++) m_addr[i] = 32'd0;
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b0;

      // Reset state
      neg();
      chk("rst_full",   {63'd0, Rob_Full}, 64'd0);
      chk("rst_commit", {63'd0, Rob_Commit}, 64'd0);
      chk("rst_bottom", {59'd0, Rob_BottomPtr}, 64'd0);
      chk("rst_topptr", {4'd0, Rob_TopPtr}, 64'd0);
      tick();

      // T1: out-of-order completion, in-order retirement
      dispatch_n(3, 0);
      neg(); chk("t1_bottom", {59'd0, Rob_BottomPtr}, 64'd3); tick();
      cdb(1, 5'd1, 0, 0, 0, 0);
      neg(); chk("t1_hold_a", {63'd0, Rob_Commit}, 64'd0); tick();
      neg(); chk("t1_hold_b", {63'd0, Rob_Commit}, 64'd0);
      tick();
      cdb(1, 5'd0, 0, 0, 0, 0);
      neg(); chk("t1_commit0", {63'd0, Rob_Commit}, 64'd1); tick();
      neg(); chk("t1_commit1", {63'd0, Rob_Commit}, 64'd1); tick();
      neg(); chk("t1_stall2",  {63'd0, Rob_Commit}, 64'd0); tick();
      cdb(1, 5'd2, 0, 0, 0, 0);
      wait_rd(6'd3, 10);

      // T3: store held by a full store buffer
      SB_Full = 1'b1;
      dispatch_one(1'b1, 1'b1, 5'd9, 6'd11, 6'd12, 6'd7);
      cdb(1, 5'd3, 32'hDEAD_BEEF, 0, 0, 0);
      neg(); chk("t3_sb_block", {63'd0, Rob_Commit}, 64'd0);
      chk("t3_sb_block_mw", {63'd0, Rob_CommitMemWrite}, 64'd0);
      tick();
      SB_Full = 1'b0;
      neg();
      chk("t3_commit", {63'd0, Rob_Commit}, 64'd1);
      chk("t3_memw",   {63'd0, Rob_CommitMemWrite}, 64'd1);
      chk("t3_addr",   {32'd0, Rob_SwAddr}, 64'hDEAD_BEEF);
      tick();
      wait_rd(6'd4, 5);

      // T5: same tag on both buses, and a CDB to an unallocated tag
      dispatch_one(1'b0, 1'b1, 5'd4, 6'd40, 6'd41, 6'd0);
      dispatch_one(1'b1, 1'b0, 5'd5, 6'd50, 6'd51, 6'd21);
      cdb(1, 5'd9, 32'h1234_5678, 0, 0, 0);
      neg();
      chk("t5_unalloc_commit", {63'd0, Rob_Commit}, 64'd0);
      chk("t5_unalloc_bottom", {59'd0, Rob_BottomPtr}, 64'd6);
      tick();
      cdb(1, 5'd5, 32'hAAAA_0001, 1, 5'd5, 32'hBBBB_0002);
      cdb(1, 5'd4, 0, 0, 0, 0);
      wait_rd(6'd6, 10);

      // T2: fill to DEPTH, then retire and dispatch in the same cycle
      dispatch_n(31, 6);
      neg(); chk("t2_not_full", {63'd0, Rob_Full}, 64'd0); tick();
      dispatch_one(1'b0, 1'b1, 5'd5, 6'd15, 6'd25, 6'd35);
      neg(); chk("t2_full", {63'd0, Rob_Full}, 64'd1); tick();
      Dis_InstValid = 1'b1;
      tick();
      Dis_InstValid = 1'b0;
      neg();
      chk("t2_reject_bottom", {59'd0, Rob_BottomPtr}, 64'd6);
      chk("t2_still_full", {63'd0, Rob_Full}, 64'd1);
      tick();
      Cdb_Valid = 2'b01; Cdb_RobTag = {5'd0, 5'd6};
      tick();
      Cdb_Valid = 2'b00;
      set_dis(1'b0, 1'b1, 5'd17, 6'd18, 6'd19, 6'd0);
      neg();
      chk("t2_commit", {63'd0, Rob_Commit}, 64'd1);
      chk("t2_full_drop", {63'd0, Rob_Full}, 64'd0);
      tick();
      Dis_InstValid = 1'b0;
      neg();
      chk("t2_refull", {63'd0, Rob_Full}, 64'd1);
      chk("t2_bottom", {59'd0, Rob_BottomPtr}, 64'd7);
      tick();

      // T4: flush rollback, wrap-bit handling
      flush(5'd4, 0, 0, 0);
      neg();
      chk("t4_bottom4", {59'd0, Rob_BottomPtr}, 64'd4);
      chk("t4_full4", {63'd0, Rob_Full}, 64'd0);
      tick();
      for (int t = 7; t <= 29; t++) cdb(1, 5'(t), 0, 0, 0, 0);
      wait_rd(6'd30, 100);
      neg(); chk("t4_head30_wait", {63'd0, Rob_Commit}, 64'd0); tick();
      flush(5'd31, 1, 1, 5'd30);
      neg();
      chk("t4_bottom31", {59'd0, Rob_BottomPtr}, 64'd31);
      chk("t4_flush_cdb_drop", {63'd0, Rob_Commit}, 64'd0);
      tick();
      dispatch_n(5, 60);
      neg(); chk("t4_bottom36", {59'd0, Rob_BottomPtr}, 64'd4); tick();
      flush(5'd2, 0, 0, 0);
      neg(); chk("t4_bottom2", {59'd0, Rob_BottomPtr}, 64'd2); tick();
      dispatch_n(27, 100);
      neg(); chk("t4_occ31", {63'd0, Rob_Full}, 64'd0); tick();
      dispatch_one(1'b0, 1'b1, 5'd1, 6'd2, 6'd3, 6'd4);
      neg(); chk("t4_occ32", {63'd0, Rob_Full}, 64'd1);
`ifdef ROB_OCCUPANCY_EN
      chk("t6_count32", {58'd0, Rob_Count}, 64'd32);
      chk("t6_af32", {63'd0, Rob_AlmostFull}, 64'd1);
`endif
      tick();

      // Asynchronous reset while full
      #2 Reset = 1'b1;
      #1;
      chk("arst_full",   {63'd0, Rob_Full}, 64'd0);
      chk("arst_commit", {63'd0, Rob_Commit}, 64'd0);
      chk("arst_bottom", {59'd0, Rob_BottomPtr}, 64'd0);
      chk("arst_topptr", {4'd0, Rob_TopPtr}, 64'd0);
      q.delete(); m_rd = 0; m_wr = 0;
      tick();
      Reset = 1'b0;

`ifdef ROB_OCCUPANCY_EN
      // T6: occupancy count and almost-full threshold
      dispatch_n(29, 0);
      neg();
      chk("t6_count29", {58'd0, Rob_Count}, 64'd29);
      chk("t6_af29", {63'd0, Rob_AlmostFull}, 64'd0);
      tick();
      dispatch_one(1'b0, 1'b1, 5'd29, 6'd1, 6'd2, 6'd3);
      neg();
      chk("t6_count30", {58'd0, Rob_Count}, 64'd30);
      chk("t6_af30", {63'd0, Rob_AlmostFull}, 64'd1);
      tick();
      #2 Reset = 1'b1;
      #1;
      chk("t6_rst_count", {58'd0, Rob_Count}, 64'd0);
      chk("t6_rst_topptr", {4'd0, Rob_TopPtr}, 64'd0);
      q.delete(); m_rd = 0; m_wr = 0;
      tick();
      Reset = 1'b0;
`endif

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
